// File: rtl/adder_pkg.sv
// Shared types and the saturating-add helper for the adder sum accumulator.
package adder_pkg;

    // Frame state: collecting sums, or presenting a finished total.
    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } acc_state_e;

    // Widest accumulator the helper supports; callers zero-extend into this.
    localparam int SAT_MAX_W = 64;

    typedef struct packed {
        logic [SAT_MAX_W-1:0] total;
        logic                 overflow;
    } sat_add_t;

    // Adds two unsigned values that each fit in 'width' bits. The result is
    // clamped to 2**width-1 when the true sum needs a (width+1)-th bit.
    function automatic sat_add_t sat_add(
        input logic [SAT_MAX_W-1:0] acc,
        input logic [SAT_MAX_W-1:0] sum,
        input int unsigned          width
    );
        logic [SAT_MAX_W:0] full;
        logic [SAT_MAX_W:0] limit;
        logic [SAT_MAX_W:0] max_v;
        sat_add_t           r;
        full       = {1'b0, acc} + {1'b0, sum};
        limit      = {{SAT_MAX_W{1'b0}}, 1'b1} << width;
        max_v      = limit - {{SAT_MAX_W{1'b0}}, 1'b1};
        // Both operands are below 2**width, so reaching the limit is exactly
        // a carry out of the width-bit adder.
        r.overflow = (full >= limit);
        r.total    = r.overflow ? max_v[SAT_MAX_W-1:0] : full[SAT_MAX_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/adder_sat_add.sv
// Combinational saturating adder: running total plus one adder sum.
module adder_sat_add
    import adder_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = 8
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    input  logic [DATA_WIDTH:0]   sum,
    output logic [ACC_WIDTH-1:0]  total,
    output logic                  overflow
);

    sat_add_t r;
    logic     high_bits;

    // Widen both operands, add with clamp, then narrow back to the accumulator width.
    always_comb begin
        r = sat_add(SAT_MAX_W'(acc), SAT_MAX_W'(sum), ACC_WIDTH);
        total = r.total[ACC_WIDTH-1:0];
    end

    // Bits above the accumulator width are always zero for in-range operands;
    // folding them into the overflow flag keeps every result bit accounted for.
    generate
        if (ACC_WIDTH < SAT_MAX_W) begin : g_narrow
            assign high_bits = |r.total[SAT_MAX_W-1:ACC_WIDTH];
        end else begin : g_full
            assign high_bits = 1'b0;
        end
    endgenerate

    assign overflow = r.overflow | high_bits;

endmodule

// File: rtl/adder_sum_accumulator.sv
// Frames the adder's sum stream: accumulates COUNT accepted sums into a
// saturating total and hands each total out on a valid/ready port.
module adder_sum_accumulator
    import adder_pkg::*;
#(
    parameter int  DATA_WIDTH = 4,
    parameter int  COUNT      = 8,
    parameter int  ACC_WIDTH  = 8,
    localparam int CNT_W      = $clog2(COUNT + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH:0]   i_sum,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_clear,
    output logic [ACC_WIDTH-1:0]  o_acc,
    output logic                  o_sat,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [CNT_W-1:0]      o_count
);

    acc_state_e           state_reg, state_next;
    logic [ACC_WIDTH-1:0] acc_reg,   acc_next;
    logic                 sat_reg,   sat_next;
    logic [CNT_W-1:0]     count_reg, count_next;

    logic [ACC_WIDTH-1:0] add_total;
    logic                 add_overflow;

    adder_sat_add #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_sat_add (
        .acc      (acc_reg),
        .sum      (i_sum),
        .total    (add_total),
        .overflow (add_overflow)
    );

    // Handshakes are pure state decodes so neither depends on any input.
    assign o_ready = (state_reg == ACCUM);
    assign o_valid = (state_reg == OUTPUT);
    assign o_acc   = acc_reg;
    assign o_sat   = sat_reg;
    assign o_count = count_reg;

    // Next-state logic: clear beats everything, then accept in ACCUM or take in OUTPUT.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        sat_next   = sat_reg;
        count_next = count_reg;
        if (i_clear) begin
            state_next = ACCUM;
            acc_next   = '0;
            sat_next   = 1'b0;
            count_next = '0;
        end else if (state_reg == ACCUM) begin
            // i_sum only reaches the registers on an accept, so an unknown
            // sum during idle cycles never lands in the total.
            if (i_valid) begin
                acc_next   = add_total;
                sat_next   = sat_reg | add_overflow;
                count_next = count_reg + CNT_W'(1);
                if (count_reg == CNT_W'(COUNT - 1)) begin
                    state_next = OUTPUT;
                end
            end
        end else if (i_ready) begin
            // Result taken: start a fresh frame; nothing is accepted this cycle.
            state_next = ACCUM;
            acc_next   = '0;
            sat_next   = 1'b0;
            count_next = '0;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ACCUM;
            acc_reg   <= '0;
            sat_reg   <= 1'b0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            sat_reg   <= sat_next;
            count_reg <= count_next;
        end
    end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Bench for adder_sum_accumulator: three instances (default, 7-bit total,
// single-sum frames) driven from one directed/randomized sequence and
// compared against a plain-arithmetic frame model.
module tb_adder_sum_accumulator;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic       i_rst_n;
    logic [4:0] sum_in   [3];
    logic       valid_in [3];
    logic       clear_in [3];
    logic       take_in  [3];

    logic [7:0] acc_w   [3];
    logic [3:0] cnt_w   [3];
    logic       sat_w   [3];
    logic       valid_w [3];
    logic       ready_w [3];

    logic [6:0] acc1;
    logic [0:0] cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: true (unclamped) running sum and number of accepted sums per instance.
    int unsigned m_sum [3];
    int          m_n   [3];

    adder_sum_accumulator #(.DATA_WIDTH(4), .COUNT(8), .ACC_WIDTH(8)) dut0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sum(sum_in[0]), .i_valid(valid_in[0]),
        .o_ready(ready_w[0]), .i_clear(clear_in[0]), .o_acc(acc_w[0]), .o_sat(sat_w[0]),
        .o_valid(valid_w[0]), .i_ready(take_in[0]), .o_count(cnt_w[0])
    );

    adder_sum_accumulator #(.DATA_WIDTH(4), .COUNT(8), .ACC_WIDTH(7)) dut1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sum(sum_in[1]), .i_valid(valid_in[1]),
        .o_ready(ready_w[1]), .i_clear(clear_in[1]), .o_acc(acc1), .o_sat(sat_w[1]),
        .o_valid(valid_w[1]), .i_ready(take_in[1]), .o_count(cnt_w[1])
    );

    adder_sum_accumulator #(.DATA_WIDTH(4), .COUNT(1), .ACC_WIDTH(8)) dut2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sum(sum_in[2]), .i_valid(valid_in[2]),
        .o_ready(ready_w[2]), .i_clear(clear_in[2]), .o_acc(acc_w[2]), .o_sat(sat_w[2]),
        .o_valid(valid_w[2]), .i_ready(take_in[2]), .o_count(cnt2)
    );

    assign acc_w[1] = {1'b0, acc1};
    assign cnt_w[2] = {3'b000, cnt2};

    function automatic int frame_len(input int d);
        return (d == 2) ? 1 : 8;
    endfunction

    function automatic int unsigned max_val(input int d);
        return (d == 1) ? 127 : 255;
    endfunction

    function automatic logic [31:0] exp_acc(input int d);
        return (m_sum[d] > max_val(d)) ? max_val(d) : m_sum[d];
    endfunction

    function automatic logic [31:0] exp_sat(input int d);
        return (m_sum[d] > max_val(d)) ? 32'd1 : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic model_clear(input int d);
        m_sum[d] = 0;
        m_n[d]   = 0;
    endtask

    // Present one sum and hold it until accepted (bounded), then check the outcome.
    task automatic offer(input int d, input logic [4:0] s);
        int waited = 0;
        sum_in[d]   = s;
        valid_in[d] = 1'b1;
        while (ready_w[d] !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) check("ready_timeout", 32'(ready_w[d]), 32'd1);
        tick();
        valid_in[d] = 1'b0;
        sum_in[d]   = 'x;
        m_sum[d] += s;
        m_n[d]++;
        if (m_n[d] == frame_len(d)) begin
            check("frame_valid", 32'(valid_w[d]), 32'd1);
            check("frame_ready_low", 32'(ready_w[d]), 32'd0);
            check("frame_acc", 32'(acc_w[d]), exp_acc(d));
            check("frame_sat", 32'(sat_w[d]), exp_sat(d));
            check("frame_count", 32'(cnt_w[d]), 32'(frame_len(d)));
            $display("dut%0d frame: acc=%0d sat=%0d (model sum %0d)", d, acc_w[d], sat_w[d], m_sum[d]);
        end else begin
            check("running_acc", 32'(acc_w[d]), exp_acc(d));
            check("running_count", 32'(cnt_w[d]), 32'(m_n[d]));
            check("running_valid_low", 32'(valid_w[d]), 32'd0);
        end
    endtask

    // Hold the consumer off for n cycles; the finished total must not move.
    task automatic stall(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("stall_valid", 32'(valid_w[d]), 32'd1);
            check("stall_ready_low", 32'(ready_w[d]), 32'd0);
            check("stall_acc", 32'(acc_w[d]), exp_acc(d));
            check("stall_sat", 32'(sat_w[d]), exp_sat(d));
        end
    endtask

    task automatic take(input int d);
        take_in[d] = 1'b1;
        tick();
        take_in[d] = 1'b0;
        model_clear(d);
        check("take_valid_low", 32'(valid_w[d]), 32'd0);
        check("take_ready", 32'(ready_w[d]), 32'd1);
        check("take_count", 32'(cnt_w[d]), 32'd0);
        check("take_acc", 32'(acc_w[d]), 32'd0);
    endtask

    task automatic clear_with_input(input int d, input logic [4:0] s);
        clear_in[d] = 1'b1;
        valid_in[d] = 1'b1;
        sum_in[d]   = s;
        tick();
        clear_in[d] = 1'b0;
        valid_in[d] = 1'b0;
        sum_in[d]   = 'x;
        model_clear(d);
        check("clear_count", 32'(cnt_w[d]), 32'd0);
        check("clear_acc", 32'(acc_w[d]), 32'd0);
        check("clear_valid_low", 32'(valid_w[d]), 32'd0);
        check("clear_ready", 32'(ready_w[d]), 32'd1);
    endtask

    task automatic random_frame(input int d, input int lo, input int hi);
        for (int i = 0; i < frame_len(d); i++) begin
            idle($urandom_range(0, 2));
            offer(d, 5'($urandom_range(lo, hi)));
        end
        stall(d, $urandom_range(0, 3));
        take(d);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            sum_in[d]   = 'x;
            valid_in[d] = 1'b0;
            clear_in[d] = 1'b0;
            take_in[d]  = 1'b0;
            model_clear(d);
        end
        i_rst_n = 1'b0;
        idle(2);

        // Reset values while reset is held.
        for (int d = 0; d < 3; d++) begin
            check("reset_acc", 32'(acc_w[d]), 32'd0);
            check("reset_sat", 32'(sat_w[d]), 32'd0);
            check("reset_valid", 32'(valid_w[d]), 32'd0);
            check("reset_count", 32'(cnt_w[d]), 32'd0);
        end
        i_rst_n = 1'b1;
        tick();
        for (int d = 0; d < 3; d++) check("release_ready", 32'(ready_w[d]), 32'd1);

        // Sums 1..8 back-to-back -> 36.
        for (int s = 1; s <= 8; s++) offer(0, 5'(s));
        take(0);

        // 7-bit total: 8x30 saturates to 127, then 8x1 gives 8 unsaturated.
        for (int i = 0; i < 8; i++) offer(1, 5'd30);
        take(1);
        for (int i = 0; i < 8; i++) offer(1, 5'd1);
        take(1);

        // 8x2 then a 5-cycle stall with a sum waiting; it is accepted only after the take.
        for (int i = 0; i < 8; i++) offer(0, 5'd2);
        sum_in[0]   = 5'd3;
        valid_in[0] = 1'b1;
        stall(0, 5);
        take(0);
        for (int i = 0; i < 8; i++) offer(0, 5'd3);
        take(0);

        // Clear after 3 accepts, with a sum of 9 offered in the same cycle.
        for (int i = 0; i < 3; i++) offer(0, 5'd5);
        clear_with_input(0, 5'd9);
        for (int i = 0; i < 8; i++) offer(0, 5'd1);
        take(0);

        // Clear while a result is pending drops it.
        for (int i = 0; i < 8; i++) offer(0, 5'd4);
        stall(0, 2);
        clear_with_input(0, 5'd7);

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 5; i++) offer(0, 5'd6);
        #3;
        i_rst_n = 1'b0;
        #1;
        check("async_acc", 32'(acc_w[0]), 32'd0);
        check("async_count", 32'(cnt_w[0]), 32'd0);
        check("async_valid", 32'(valid_w[0]), 32'd0);
        tick();
        i_rst_n = 1'b1;
        for (int d = 0; d < 3; d++) model_clear(d);
        tick();
        random_frame(0, 0, 31);

        // Single-sum frames with gaps: 30, 0, 17.
        idle(2);
        offer(2, 5'd30);
        take(2);
        idle(3);
        offer(2, 5'd0);
        take(2);
        idle(1);
        offer(2, 5'd17);
        take(2);

        // Randomized frames across all three configurations.
        for (int f = 0; f < 6; f++) begin
            random_frame(0, 0, 31);
            random_frame(1, 10, 31);
            random_frame(2, 0, 31);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
